mantissa_normalizer: RTL

Post-addition normalizer for the bfloat16 floating point adder (1 sign, 8-bit biased exponent, 7-bit stored mantissa). It accepts the raw 9-bit sum mantissa, exponent and sign from the add stage, which follows mantissa alignment. It renormalizes the mantissa iteratively, one bit position per cycle, then optionally rounds and packs a 16-bit result. It undoes what alignment did: alignment denormalizes operands to a common exponent; this block restores a single leading one and adjusts the exponent to match.

---
 rtl/mantissa_normalizer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mantissa_normalizer.sv
// mantissa_normalizer: post-addition normalizer for a bfloat16 adder.
// Takes the raw 9-bit sum mantissa (carry, hidden one, 7-bit fraction),
// the exponent of the larger operand, the sign, and the guard/sticky bits
// left over from alignment. It renormalizes one bit position per cycle,
// then rounds (or truncates) and packs {sign, exp[7:0], mant[6:0]}.
// Build option: define NORM_ROUND_EN for round-to-nearest-even in ROUND;
// without it the ROUND state truncates and only passes through.
module mantissa_normalizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [8:0]  in_mant,
    input  logic        in_guard,
    input  logic        in_sticky,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_ovf,
    output logic        out_unf
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  exp_q, exp_d;
    logic [8:0]  mant_q, mant_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic [15:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        valid_q, valid_d;

    logic [8:0]  exp_inc;
    logic [8:0]  exp_r;
    logic [8:0]  mant_r;

    assign exp_inc = {1'b0, exp_q} + 9'd1;

`ifdef NORM_ROUND_EN
    // Round to nearest even: bump when above half, or exactly half and odd.
    function automatic logic [8:0] round_mant(input logic [8:0] mant,
                                              input logic       guard,
                                              input logic       sticky);
        round_mant = mant + {8'd0, guard & (sticky | mant[0])};
    endfunction
`endif

    // Next-state and datapath: one normalization step per cycle in SHIFT.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        valid_d  = valid_q;
        mant_r   = mant_q;
        exp_r    = {1'b0, exp_q};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = in_sign;
                    exp_d    = in_exp;
                    mant_d   = in_mant;
                    guard_d  = in_guard;
                    sticky_d = in_sticky;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (mant_q == 9'd0 || exp_q == 8'd0) begin
                    // Exact cancellation (or zero operands) always gives +0.
                    result_d = 16'h0000;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else if (mant_q[8]) begin
                    // Carry out of the add: one right shift always suffices.
                    mant_d   = {1'b0, mant_q[8:1]};
                    guard_d  = mant_q[0];
                    sticky_d = sticky_q | guard_q;
                    exp_d    = exp_inc[7:0];
                    if (exp_inc >= 9'd255) begin
                        result_d = {sign_q, 8'hFF, 7'h00};
                        ovf_d    = 1'b1;
                        unf_d    = 1'b0;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = ROUND;
                    end
                end else if (mant_q[7]) begin
                    state_d = ROUND;
                end else if (exp_q <= 8'd1) begin
                    // No denormals: running out of exponent flushes to zero.
                    result_d = {sign_q, 15'h0000};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    // Guard bit re-enters as the new LSB; only one is kept.
                    mant_d  = {mant_q[7:0], guard_q};
                    guard_d = 1'b0;
                    exp_d   = exp_q - 8'd1;
                end
            end
            ROUND: begin
`ifdef NORM_ROUND_EN
                mant_r = round_mant(mant_q, guard_q, sticky_q);
                if (mant_r[8]) begin
                    mant_r = 9'h080;
                    exp_r  = exp_inc;
                end
`endif
                mant_d = mant_r;
                exp_d  = exp_r[7:0];
                if (exp_r >= 9'd255) begin
                    result_d = {sign_q, 8'hFF, 7'h00};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_r[7:0], mant_r[6:0]};
                    ovf_d    = 1'b0;
                end
                unf_d   = 1'b0;
                valid_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Control and output registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= 16'h0000;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Working operand registers; contents only matter after a capture.
    always_ff @(posedge clk) begin
        sign_q   <= sign_d;
        exp_q    <= exp_d;
        mant_q   <= mant_d;
        guard_q  <= guard_d;
        sticky_q <= sticky_d;
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_ovf    = ovf_q;
    assign out_unf    = unf_q;

endmodule
